// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-entry skid buffer and IF/ID register.
// Optional stall counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] ID_instr,
  output logic [15:0] ID_PC_INC_OUT,
  output logic        ID_valid,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic [15:0] pc_nxt;
  logic [15:0] pc_inc;
  logic [15:0] buf_q;
  logic [15:0] word;
  logic        ld;
  logic        bub;
  logic        buf_ld;

  assign pc_inc    = pc + 16'd2;
  assign imem_addr = pc;
  assign imem_req  = rst_n && (state == S_FETCH);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ld        = 1'b0;
    bub       = 1'b0;
    buf_ld    = 1'b0;
    word      = imem_data;
    if (br_taken) begin
      state_nxt = S_FETCH;
      pc_nxt    = br_target;
      bub       = 1'b1;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_valid) begin
            if (stall) begin
              buf_ld    = 1'b1;
              state_nxt = S_HOLD;
            end else begin
              ld = 1'b1;
            end
          end else if (!stall) begin
            bub = 1'b1;
          end
        end
        S_HOLD: begin
          word = buf_q;
          ld   = !stall;
        end
        S_HALT: bub = !stall;
        default: state_nxt = S_FETCH;
      endcase
      // HLT freezes the PC on its own address
      if (ld) begin
        if (word[15:12] == 4'hF) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
          pc_nxt    = pc_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      pc            <= 16'h0000;
      buf_q         <= 16'h0000;
      ID_instr      <= 16'h0000;
      ID_PC_INC_OUT <= 16'h0000;
      ID_valid      <= 1'b0;
      halted        <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      halted <= (state_nxt == S_HALT);
      if (buf_ld) begin
        buf_q <= imem_data;
      end
      if (ld) begin
        ID_instr      <= word;
        ID_PC_INC_OUT <= pc_inc;
        ID_valid      <= 1'b1;
      end else if (bub) begin
        ID_instr <= 16'h0000;
        ID_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'h0000;
    end else if (!br_taken && cnt != 16'hFFFF &&
                 (stall || (state == S_FETCH && !imem_valid))) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign stall_cycles = cnt;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL: stall  in  1  hazard-unit hold; freezes PC and IF/ID outputs.
REQ-004 SHALL: br_taken  in  1  redirect from ID (branch/jump resolved taken).
REQ-005 SHALL: br_target  in  16  redirect PC, valid when br_taken=1.
REQ-006 SHALL: imem_req  out  1  instruction fetch request; address held stable while high.
REQ-007 SHALL: imem_addr  out  16  fetch address, always equal to the PC register.
REQ-008 SHALL: imem_data  in  16  instruction word, valid when imem_valid=1.
REQ-009 SHALL: imem_valid  in  1  fetch complete; arrives 1..N cycles after imem_req rises.
REQ-010 SHALL: ID_instr  out  16  registered instruction presented to decode.
REQ-011 SHALL: ID_PC_INC_OUT  out  16  registered fetch PC + 2.
REQ-012 SHALL: ID_valid  out  1  registered; 0 marks a bubble (ID_instr = 16'h0000).
REQ-013 SHALL: halted  out  1  registered; high once HLT (opcode 4'hF) has been fetched.
REQ-014 SHALL: stall_cycles  out  16  fetch-stall performance count (see Configuration).

Function
REQ-015 SHALL: three-state FSM: FETCH (imem_req=1), HOLD (imem_req=0, instruction buffered), HALT (imem_req=0, halted=1).
REQ-016 SHALL: FETCH with imem_valid=1 and stall=0 loads IF/ID {imem_data, PC+2, 1}, sets PC<=PC+2, and stays in FETCH.
REQ-017 SHALL: FETCH with imem_valid=1 and stall=1 captures imem_data into a one-entry buffer, holds PC and IF/ID, and moves to HOLD.
REQ-018 SHALL: HOLD with stall=0 loads IF/ID from the buffer, sets PC<=PC+2, and returns to FETCH; HOLD with stall=1 holds everything.
REQ-019 SHALL: FETCH with imem_valid=0 loads a bubble into IF/ID when stall=0 and holds IF/ID when stall=1; PC is held.
REQ-020 SHALL: br_taken=1 in any state, including while stall=1, take priority over all other events. It sets PC<=br_target, loads a bubble into IF/ID, discards the buffer and any imem_valid in the same cycle, and moves to FETCH.
REQ-021 SHALL: when an instruction with [15:12]=4'hF is loaded into IF/ID (from FETCH or HOLD), hold PC at the HLT address, keep ID_PC_INC_OUT=HLT address+2, and move to HALT.
REQ-022 SHALL: HALT loads bubbles into IF/ID when stall=0 and holds IF/ID when stall=1; it exits only on br_taken or reset.
REQ-023 SHALL: PC+2 wrap modulo 2^16 (16'hFFFE+2 = 16'h0000) with no flag.
REQ-024 SHALL: latency from imem_valid (stall=0) to ID outputs is exactly one clock edge.

Reset
REQ-025 SHALL: rst_n=0 immediately set PC=0, state=FETCH, buffer empty, ID_instr=0, ID_PC_INC_OUT=0, ID_valid=0, halted=0, stall_cycles=0.
REQ-026 SHALL: imem_req be 0 while rst_n=0; the first fetch request (address 16'h0000) is issued in the first cycle after release.
REQ-027 SHALL: reset asserted during an outstanding fetch abandon it; any late imem_valid after release and before a new request is ignored.

Configuration
REQ-028 SHALL: with macro FETCH_STALL_CNT_EN defined, stall_cycles increment once per cycle in which stall=1 or (state=FETCH and imem_valid=0), saturating at 16'hFFFF; br_taken cycles are not counted.
REQ-029 SHALL: without FETCH_STALL_CNT_EN, keep the stall_cycles port present and tied to 16'h0000, with no counter flops.

Verification
REQ-030 SHALL: release reset, imem_valid=1 every cycle with 0x1234,0x5678 -> ID_instr 0x1234/PC_INC 0x0002, then 0x5678/0x0004.
REQ-031 SHALL: imem_valid at PC=0x0010 with stall=1 for 3 cycles -> HOLD, imem_req=0, IF/ID unchanged; on stall=0 the next edge gives ID_instr=buffered word, PC=0x0012.
REQ-032 SHALL: br_taken=1, br_target=0x0400 together with stall=1 and imem_valid=1 -> ID_valid=0, next imem_addr=0x0400, buffer empty.
REQ-033 SHALL: fetch 0xF000 at PC=0x0020 -> halted=1, imem_req=0, ID_PC_INC_OUT=0x0022, bubbles thereafter; br_taken to 0x0000 resumes FETCH.
REQ-034 SHALL: with FETCH_STALL_CNT_EN, imem_valid held low 70000 cycles -> stall_cycles=16'hFFFF; without the macro -> 16'h0000.
REQ-035 SHALL: PC=0xFFFE fetch with stall=0 -> ID_PC_INC_OUT=0x0000, next imem_addr=0x0000.
